fir_tap_scheduler: RTL and testbench
====================================

# fir_tap_scheduler

Control FSM that sequences the FIR accelerator's tap datapath for one input sample at a time. On each accepted sample it shifts the delay line, clears the accumulator, and steps an internal tap counter through every coefficient index with MAC enabled. It then holds the result until the AHB-Lite slave side acknowledges it. It sits between the AHB-Lite slave register block (sample/result handshakes) and the coefficient/sample/MAC datapath.

## Interface
- NUM_TAPS, default 4: number of filter taps. Legal range is 1..2^CNT_BITS.
- CNT_BITS, default 4: width of tap counter and tap_sel. Must be ≥ clog2(NUM_TAPS), minimum 1.
- clk, input, 1: system clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous abort. Returns to IDLE; priority over all other inputs.
- sample_valid, input, 1: new sample present; held high by source until sample_ack.
- sample_ack, output, 1: one-cycle pulse; the sample has been taken into the delay line.
- shift_en, output, 1: shift sample delay line (one cycle per sample).
- clear_acc, output, 1: zero the accumulator (same cycle as shift_en).
- mac_en, output, 1: accumulate sample[tap_sel]·coeff[tap_sel].
- tap_sel, output, CNT_BITS: current tap index during MAC; 0 otherwise.
- result_valid, output, 1: accumulator holds final result; held until result_ack.
- result_ack, input, 1: consumer has read the result.
- busy, output, 1: high in every state except IDLE.
- sample_cnt, output, 8: number of completed results (result handshakes), wraps 255→0.

## Operation
- Four states: IDLE, SHIFT, MAC, DONE. All outputs are Moore-decoded from registered state/counters.
- IDLE:
  - Outputs all 0.
  - sample_valid=1 → SHIFT.
- SHIFT (exactly 1 cycle):
  - sample_ack=shift_en=clear_acc=1.
  - Tap counter loads 0.
  - → MAC.
- MAC (exactly NUM_TAPS cycles):
  - mac_en=1; tap_sel = tap counter.
  - Counter increments each cycle.
  - When tap_sel == NUM_TAPS-1 → DONE; counter rolls over to 0.
- DONE:
  - result_valid=1.
  - result_ack=1 → IDLE; sample_cnt increments by 1 on that edge.
  - result_ack without result_valid (any other state) is ignored.
- flush=1 at an edge:
  - State → IDLE, tap counter → 0, sample_cnt unchanged.
  - An in-flight result is discarded and not counted.
  - flush overrides sample_valid and result_ack in the same cycle.
- NUM_TAPS=1: MAC lasts one cycle with tap_sel=0.
- sample_valid dropping before ack (protocol violation): the FSM still completes if already in SHIFT or later. In IDLE nothing happens.

## Timing
- Reset values: state=IDLE, tap counter=0, sample_cnt=0. All outputs 0 while rst=1 and on the first cycle after release.
- Let k be the edge at which sample_valid is sampled high in IDLE:
  - Cycle k+1: SHIFT.
  - Cycles k+2 .. k+1+NUM_TAPS: MAC.
  - result_valid first high in cycle k+2+NUM_TAPS.
- Minimum sample period (ack same cycle as result_valid): NUM_TAPS+3 cycles without back-to-back, NUM_TAPS+2 with back-to-back.
- rst mid-operation: immediate return to reset values, independent of clk.

## Configuration
- FIR_SCHED_B2B_EN:
  - Defined: in DONE with result_ack=1 and sample_valid=1, go directly to SHIFT, skipping IDLE. sample_cnt still increments.
  - Undefined: DONE always returns to IDLE first, and a sample is accepted at the earliest one cycle later.

## Test plan
- Reset: assert rst asynchronously mid-cycle. Required: all outputs 0, busy=0, sample_cnt=0 immediately; the same values held one full cycle after release.
- Single sample, NUM_TAPS=4:
  - Hold sample_valid high from the edge where IDLE samples it.
  - Required: sample_ack/shift_en/clear_acc high 1 cycle, then mac_en for 4 cycles with tap_sel 0,1,2,3.
  - Then result_valid high and held 3 cycles until result_ack. On the ack: IDLE and sample_cnt=1.
- Flush during MAC at tap_sel=2. Required: next cycle IDLE, mac_en=0, tap_sel=0, result_valid never asserted, sample_cnt unchanged.
- Back-to-back: sample_valid held high and result_ack asserted on the first result_valid cycle.
  - Required with FIR_SCHED_B2B_EN: SHIFT the next cycle (period 6 for NUM_TAPS=4).
  - Required without it: one IDLE cycle (period 7).
- Spurious result_ack asserted during IDLE and MAC. Required: no state change, sample_cnt unchanged.
- Counter wrap: complete 256 samples. Required: sample_cnt reads 255 after 255 results and 0 after the 256th.

Source files
------------

// File: rtl/fir_tap_scheduler.sv
// Tap-sequencing control FSM for the FIR accelerator: IDLE -> SHIFT -> MAC x NUM_TAPS -> DONE.
// Define FIR_SCHED_B2B_EN to let DONE hand off directly to SHIFT when a new sample is already waiting.
module fir_tap_scheduler #(
  parameter int NUM_TAPS = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                sample_valid,
  input  logic                result_ack,
  output logic                sample_ack,
  output logic                shift_en,
  output logic                clear_acc,
  output logic                mac_en,
  output logic [CNT_BITS-1:0] tap_sel,
  output logic                result_valid,
  output logic                busy,
  output logic [7:0]          sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_DONE
  } state_t;

  localparam logic [CNT_BITS-1:0] LAST_TAP = CNT_BITS'(NUM_TAPS - 1);

`ifdef FIR_SCHED_B2B_EN
  localparam bit B2B_EN = 1'b1;
`else
  localparam bit B2B_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] tap_cnt_q, tap_cnt_d;
  logic [7:0]          cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tap_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  // flush wins over everything; only an acknowledged result advances the result count
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    cnt_d     = cnt_q;
    if (flush) begin
      state_d   = S_IDLE;
      tap_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sample_valid) state_d = S_SHIFT;
        end
        S_SHIFT: begin
          tap_cnt_d = '0;
          state_d   = S_MAC;
        end
        S_MAC: begin
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_BITS'(1);
          end
        end
        S_DONE: begin
          if (result_ack) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (B2B_EN && sample_valid) ? S_SHIFT : S_IDLE;
          end
        end
        default: begin
          state_d   = S_IDLE;
          tap_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sample_ack   = 1'b0;
    shift_en     = 1'b0;
    clear_acc    = 1'b0;
    mac_en       = 1'b0;
    tap_sel      = '0;
    result_valid = 1'b0;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_SHIFT: begin
        sample_ack = 1'b1;
        shift_en   = 1'b1;
        clear_acc  = 1'b1;
      end
      S_MAC: begin
        mac_en  = 1'b1;
        tap_sel = tap_cnt_q;
      end
      S_DONE:  result_valid = 1'b1;
      default: ;
    endcase
  end

  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboard bench for fir_tap_scheduler (NUM_TAPS=4): each scenario queues its expected
// per-cycle outputs before driving stimulus, then pops and compares them cycle by cycle.
module tb_fir_tap_scheduler;

  logic       tb_clk;
  logic       rst;
  logic       flush;
  logic       sample_valid;
  logic       result_ack;
  logic       sample_ack;
  logic       shift_en;
  logic       clear_acc;
  logic       mac_en;
  logic [3:0] tap_sel;
  logic       result_valid;
  logic       busy;
  logic [7:0] sample_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs;

  fir_tap_scheduler #(.NUM_TAPS(4), .CNT_BITS(4)) dut (
    .clk(tb_clk),
    .rst(rst),
    .flush(flush),
    .sample_valid(sample_valid),
    .sample_ack(sample_ack),
    .shift_en(shift_en),
    .clear_acc(clear_acc),
    .mac_en(mac_en),
    .tap_sel(tap_sel),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .busy(busy),
    .sample_cnt(sample_cnt)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  assign obs = {sample_ack, shift_en, clear_acc, mac_en, tap_sel, result_valid, busy, sample_cnt};

  // expected output vector for a state (0 idle, 1 shift, 2 mac, 3 done)
  function automatic logic [17:0] ev(input int st, input int tap, input int cnt);
    logic [3:0] t;
    logic [7:0] c;
    t = 4'(tap);
    c = 8'(cnt);
    case (st)
      1:       return {3'b111, 1'b0, 4'd0, 1'b0, 1'b1, c};
      2:       return {3'b000, 1'b1, t, 1'b0, 1'b1, c};
      3:       return {3'b000, 1'b0, 4'd0, 1'b1, 1'b1, c};
      default: return {3'b000, 1'b0, 4'd0, 1'b0, 1'b0, c};
    endcase
  endfunction

  task automatic test_reset_values;
    logic [17:0] e;
    exp_cnt = 0;
    repeat (3) exp_q.push_back(ev(0, 0, 0));
    #2;
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got %h expected %h", obs, e);
    end
    @(negedge tb_clk);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_edge: got %h expected %h", obs, e);
    end
    rst = 1'b0;
    @(negedge tb_clk);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_single;
    logic [17:0] e;
    @(negedge tb_clk);
    exp_q.push_back(ev(1, 0, exp_cnt));
    for (int t = 0; t < 4; t++) exp_q.push_back(ev(2, t, exp_cnt));
    repeat (3) exp_q.push_back(ev(3, 0, exp_cnt));
    exp_cnt++;
    exp_q.push_back(ev(0, 0, exp_cnt));
    sample_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge tb_clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("[TB] FAIL single cycle %0d: got %h expected %h", i, obs, e);
      end
      if (i == 0) sample_valid = 1'b0;
      if (i == 7) result_ack = 1'b1;
      if (i == 8) result_ack = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [17:0] e;
    @(negedge tb_clk);
    sample_valid = 1'b1;
    @(negedge tb_clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge tb_clk);
    exp_cnt = 0;
    repeat (3) exp_q.push_back(ev(0, 0, 0));
    #2 rst = 1'b1;
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_immediate: got %h expected %h", obs, e);
    end
    @(negedge tb_clk);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_held: got %h expected %h", obs, e);
    end
    rst = 1'b0;
    @(negedge tb_clk);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_release: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_flush;
    logic [17:0] e;
    @(negedge tb_clk);
    exp_q.push_back(ev(1, 0, exp_cnt));
    for (int t = 0; t < 3; t++) exp_q.push_back(ev(2, t, exp_cnt));
    repeat (3) exp_q.push_back(ev(0, 0, exp_cnt));
    sample_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge tb_clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("[TB] FAIL flush cycle %0d: got %h expected %h", i, obs, e);
      end
      if (i == 0) sample_valid = 1'b0;
      if (i == 3) flush = 1'b1;
      if (i == 4) flush = 1'b0;
    end
  endtask

  task automatic test_spurious_ack;
    logic [17:0] e;
    @(negedge tb_clk);
    result_ack = 1'b1;
    exp_q.push_back(ev(0, 0, exp_cnt));
    exp_q.push_back(ev(1, 0, exp_cnt));
    for (int t = 0; t < 4; t++) exp_q.push_back(ev(2, t, exp_cnt));
    exp_q.push_back(ev(3, 0, exp_cnt));
    exp_cnt++;
    exp_q.push_back(ev(0, 0, exp_cnt));
    for (int i = 0; i < 8; i++) begin
      @(negedge tb_clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("[TB] FAIL spurious_ack cycle %0d: got %h expected %h", i, obs, e);
      end
      case (i)
        0: begin result_ack = 1'b0; sample_valid = 1'b1; end
        1: begin sample_valid = 1'b0; result_ack = 1'b1; end
        5: result_ack = 1'b0;
        6: result_ack = 1'b1;
        7: result_ack = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] e;
    int gap;
`ifdef FIR_SCHED_B2B_EN
    gap = 0;
`else
    gap = 1;
`endif
    @(negedge tb_clk);
    exp_q.push_back(ev(1, 0, exp_cnt));
    for (int t = 0; t < 4; t++) exp_q.push_back(ev(2, t, exp_cnt));
    exp_q.push_back(ev(3, 0, exp_cnt));
    exp_cnt++;
    if (gap != 0) exp_q.push_back(ev(0, 0, exp_cnt));
    exp_q.push_back(ev(1, 0, exp_cnt));
    for (int t = 0; t < 4; t++) exp_q.push_back(ev(2, t, exp_cnt));
    exp_q.push_back(ev(3, 0, exp_cnt));
    exp_cnt++;
    exp_q.push_back(ev(0, 0, exp_cnt));
    sample_valid = 1'b1;
    for (int i = 0; i < 13 + gap; i++) begin
      @(negedge tb_clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", i, obs, e);
      end
      if (i == 5) result_ack = 1'b1;
      if (i == 6) result_ack = 1'b0;
      if (i == 11 + gap) begin result_ack = 1'b1; sample_valid = 1'b0; end
      if (i == 12 + gap) result_ack = 1'b0;
    end
  endtask

  task automatic test_wrap;
    logic [17:0] e;
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(ev(1, 0, exp_cnt));
      for (int t = 0; t < 4; t++) exp_q.push_back(ev(2, t, exp_cnt));
      exp_q.push_back(ev(3, 0, exp_cnt));
      exp_cnt = (exp_cnt + 1) % 256;
      exp_q.push_back(ev(0, 0, exp_cnt));
      sample_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
        @(negedge tb_clk);
        e = exp_q.pop_front();
        tests_run++;
        if (obs !== e) begin
          tests_failed++;
          $display("[TB] FAIL wrap sample %0d cycle %0d: got %h expected %h", k, i, obs, e);
        end
        if (i == 0) sample_valid = 1'b0;
        if (i == 5) result_ack = 1'b1;
        if (i == 6) result_ack = 1'b0;
      end
      if (k == 254) begin
        tests_run++;
        if (sample_cnt !== 8'd255) begin
          tests_failed++;
          $display("[TB] FAIL wrap_255: got %0d expected 255", sample_cnt);
        end
      end
    end
    tests_run++;
    if (sample_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_0: got %0d expected 0", sample_cnt);
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    sample_valid = 1'b0;
    result_ack   = 1'b0;
    test_reset_values;
    test_single;
    test_reset;
    test_flush;
    test_spurious_ack;
    test_back_to_back;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
